// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - PSR flag capture, opcode masking and branch condition evaluation.
// Optional interrupt shadow of the PSR is enabled with `define FLAG_SHADOW_EN.
module alu_flag_unit (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_alu_valid,
  input  logic [7:0] i_alu_opcode,
  input  logic       i_alu_carry,
  input  logic       i_alu_flag,
  input  logic       i_alu_low,
  input  logic       i_alu_negative,
  input  logic       i_alu_zero,
  input  logic       i_psr_we,
  input  logic [4:0] i_psr_wdata,
  input  logic       i_cond_req,
  input  logic [3:0] i_cond_code,
  input  logic       i_int_save,
  input  logic       i_int_restore,
  output logic [4:0] o_psr,
  output logic       o_carry_in,
  output logic       o_cond_valid,
  output logic       o_cond_taken
);

  localparam int NFLAGS = 5;
  localparam int F_BIT = 4;
  localparam int C_BIT = 3;
  localparam int L_BIT = 2;
  localparam int N_BIT = 1;
  localparam int Z_BIT = 0;

  logic [NFLAGS-1:0] r_psr;
  logic              r_cond_valid;
  logic              r_cond_taken;
  logic [NFLAGS-1:0] w_psr_next;
  logic [NFLAGS-1:0] w_alu_flags;
  logic [NFLAGS-1:0] w_mask;
  logic [NFLAGS-1:0] w_alu_merged;
  logic [NFLAGS-1:0] w_shadow;
  logic              w_restore;

  function automatic logic [NFLAGS-1:0] upd_mask(input logic [7:0] op);
    logic [NFLAGS-1:0] m;
    m = '0;
    case (op)
      8'd0, 8'd2, 8'd4, 8'd8, 8'd9: begin
        m[F_BIT] = 1'b1;
        m[Z_BIT] = 1'b1;
      end
      8'd1, 8'd3, 8'd5, 8'd6: begin
        m[C_BIT] = 1'b1;
        m[Z_BIT] = 1'b1;
      end
      8'd10, 8'd11: begin
        m[L_BIT] = 1'b1;
        m[N_BIT] = 1'b1;
        m[Z_BIT] = 1'b1;
      end
      8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21: m[Z_BIT] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Odd codes are the complement of the even code below them.
  function automatic logic cond_eval(input logic [3:0] code, input logic [NFLAGS-1:0] p);
    logic base;
    case (code[3:1])
      3'd0:    base = p[Z_BIT];
      3'd1:    base = p[C_BIT];
      3'd2:    base = p[L_BIT];
      3'd3:    base = p[N_BIT];
      3'd4:    base = p[F_BIT];
      3'd5:    base = p[N_BIT] | p[Z_BIT];
      3'd6:    base = p[L_BIT] | p[Z_BIT];
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  assign w_alu_flags  = {i_alu_flag, i_alu_carry, i_alu_low, i_alu_negative, i_alu_zero};
  assign w_mask       = upd_mask(i_alu_opcode);
  // AND-masking keeps unwritten (possibly X) ALU bits out of the PSR.
  assign w_alu_merged = (w_alu_flags & w_mask) | (r_psr & ~w_mask);

`ifdef FLAG_SHADOW_EN
  logic [NFLAGS-1:0] r_shadow;

  assign w_restore = i_int_restore;
  assign w_shadow  = r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow <= '0;
    end else if (i_int_save) begin
      r_shadow <= w_psr_next;
    end
  end
`else
  logic w_unused_shadow_ports;

  assign w_restore             = 1'b0;
  assign w_shadow              = '0;
  assign w_unused_shadow_ports = i_int_save ^ i_int_restore;
`endif

  always_comb begin
    w_psr_next = r_psr;
    if (w_restore) begin
      w_psr_next = w_shadow;
    end else if (i_psr_we) begin
      w_psr_next = i_psr_wdata;
    end else if (i_alu_valid) begin
      w_psr_next = w_alu_merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_psr        <= '0;
      r_cond_valid <= 1'b0;
      r_cond_taken <= 1'b0;
    end else begin
      r_psr        <= w_psr_next;
      r_cond_valid <= i_cond_req;
      if (i_cond_req) begin
        r_cond_taken <= cond_eval(i_cond_code, w_psr_next);
      end
    end
  end

  assign o_psr        = r_psr;
  assign o_carry_in   = r_psr[C_BIT];
  assign o_cond_valid = r_cond_valid;
  assign o_cond_taken = r_cond_taken;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - directed and randomized checks of alu_flag_unit against a flag model.
// Expectations follow FLAG_SHADOW_EN when it is defined for the build.
module tb_alu_flag_unit;

`ifdef FLAG_SHADOW_EN
  localparam bit SHADOW_ON = 1'b1;
`else
  localparam bit SHADOW_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [7:0] alu_opcode;
  logic       alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
  logic       psr_we;
  logic [4:0] psr_wdata;
  logic       cond_req;
  logic [3:0] cond_code;
  logic       int_save, int_restore;
  logic [4:0] o_psr;
  logic       o_carry_in, o_cond_valid, o_cond_taken;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [4:0] m_psr = '0;
  logic [4:0] m_shadow = '0;
  logic       m_cv = 1'b0;
  logic       m_ct = 1'b0;

  always #5 clk = ~clk;

  alu_flag_unit dut (
    .i_clk(clk), .i_reset(reset), .i_alu_valid(alu_valid), .i_alu_opcode(alu_opcode),
    .i_alu_carry(alu_carry), .i_alu_flag(alu_flag), .i_alu_low(alu_low),
    .i_alu_negative(alu_negative), .i_alu_zero(alu_zero), .i_psr_we(psr_we),
    .i_psr_wdata(psr_wdata), .i_cond_req(cond_req), .i_cond_code(cond_code),
    .i_int_save(int_save), .i_int_restore(int_restore), .o_psr(o_psr),
    .o_carry_in(o_carry_in), .o_cond_valid(o_cond_valid), .o_cond_taken(o_cond_taken)
  );

  function automatic logic ref_cond(input logic [3:0] code, input logic [4:0] p);
    logic f, c, l, n, z;
    {f, c, l, n, z} = p;
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return n || z;
      4'd11: return !n && !z;
      4'd12: return l || z;
      4'd13: return !l && !z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [4:0] nx;
    nx = m_psr;
    if (SHADOW_ON && int_restore) nx = m_shadow;
    else if (psr_we) nx = psr_wdata;
    else if (alu_valid) begin
      if (alu_opcode inside {8'd0, 8'd2, 8'd4, 8'd8, 8'd9}) begin
        nx[4] = alu_flag; nx[0] = alu_zero;
      end else if (alu_opcode inside {8'd1, 8'd3, 8'd5, 8'd6}) begin
        nx[3] = alu_carry; nx[0] = alu_zero;
      end else if (alu_opcode inside {8'd10, 8'd11}) begin
        nx[2] = alu_low; nx[1] = alu_negative; nx[0] = alu_zero;
      end else if (alu_opcode >= 8'd16 && alu_opcode <= 8'd21) begin
        nx[0] = alu_zero;
      end
    end
    if (reset) begin
      m_psr = '0; m_shadow = '0; m_cv = 1'b0; m_ct = 1'b0;
    end else begin
      if (cond_req) m_ct = ref_cond(cond_code, nx);
      m_cv = cond_req;
      if (SHADOW_ON && int_save) m_shadow = nx;
      m_psr = nx;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_psr", 32'(o_psr), 32'(m_psr));
      check("model_carry_in", 32'(o_carry_in), 32'(m_psr[3]));
      check("model_cond_valid", 32'(o_cond_valid), 32'(m_cv));
      check("model_cond_taken", 32'(o_cond_taken), 32'(m_ct));
    end
  end

  task automatic set_idle();
    reset = 1'b0; alu_valid = 1'b0; alu_opcode = '0;
    {alu_flag, alu_carry, alu_low, alu_negative, alu_zero} = '0;
    psr_we = 1'b0; psr_wdata = '0; cond_req = 1'b0; cond_code = '0;
    int_save = 1'b0; int_restore = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    set_idle(); reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic alu_op(input logic [7:0] op, input logic [4:0] fl);
    alu_valid = 1'b1; alu_opcode = op;
    {alu_flag, alu_carry, alu_low, alu_negative, alu_zero} = fl;
  endtask

  initial begin
    set_idle(); reset = 1'b1;
    step(); step();
    chk_en = 1'b1;
    check("reset_psr", 32'(o_psr), 32'h0);
    check("reset_cond_valid", 32'(o_cond_valid), 32'h0);
    check("reset_cond_taken", 32'(o_cond_taken), 32'h0);

    // CMP with a same-cycle LT branch sees the new flags
    set_idle(); alu_op(8'd10, 5'b00110); cond_req = 1'b1; cond_code = 4'd6;
    step();
    check("cmp_psr", 32'(o_psr), 32'h06);
    check("cmp_lt_valid", 32'(o_cond_valid), 32'h1);
    check("cmp_lt_taken", 32'(o_cond_taken), 32'h1);
    set_idle(); step();
    check("cond_valid_drop", 32'(o_cond_valid), 32'h0);
    check("cond_taken_hold", 32'(o_cond_taken), 32'h1);

    do_reset();
    set_idle(); alu_op(8'd1, 5'b11111); step();
    check("addu_psr", 32'(o_psr), 32'h09);
    check("addu_carry_in", 32'(o_carry_in), 32'h1);

    set_idle(); psr_we = 1'b1; psr_wdata = 5'b11111; step();
    set_idle(); alu_op(8'd12, 5'b00000); step();
    check("and_no_update", 32'(o_psr), 32'h1f);
    set_idle(); alu_valid = 1'b1; alu_opcode = 8'd22;
    {alu_flag, alu_carry, alu_low, alu_negative, alu_zero} = 5'bxxxxx;
    step();
    check("nop_x_flags", 32'(o_psr), 32'h1f);
    set_idle(); alu_op(8'd23, 5'b00000); step();
    check("undef_op23", 32'(o_psr), 32'h1f);
    set_idle(); alu_op(8'd21, 5'b00000); step();
    check("shift21_z_only", 32'(o_psr), 32'h1e);

    set_idle(); alu_op(8'd0, 5'b00000); psr_we = 1'b1; psr_wdata = 5'b10101; step();
    check("psr_we_wins", 32'(o_psr), 32'h15);

    set_idle(); cond_req = 1'b1; cond_code = 4'd14; step();
    check("uc_taken", 32'(o_cond_taken), 32'h1);
    set_idle(); reset = 1'b1; cond_req = 1'b1; cond_code = 4'd14; step();
    check("rst_mid_psr", 32'(o_psr), 32'h0);
    check("rst_mid_valid", 32'(o_cond_valid), 32'h0);
    check("rst_mid_taken", 32'(o_cond_taken), 32'h0);

    set_idle(); psr_we = 1'b1; psr_wdata = 5'b00001; step();
    set_idle(); int_save = 1'b1; step();
    set_idle(); psr_we = 1'b1; psr_wdata = 5'b11000; step();
    set_idle(); int_restore = 1'b1; step();
    check("shadow_restore", 32'(o_psr), SHADOW_ON ? 32'h01 : 32'h18);

    for (int i = 0; i < 3000; i++) begin
      set_idle();
      reset       = ($urandom_range(0, 99) == 0);
      alu_valid   = ($urandom_range(0, 9) < 7);
      alu_opcode  = 8'($urandom_range(0, 30));
      {alu_flag, alu_carry, alu_low, alu_negative, alu_zero} = 5'($urandom);
      psr_we      = ($urandom_range(0, 9) == 0);
      psr_wdata   = 5'($urandom);
      cond_req    = $urandom_range(0, 1) == 1;
      cond_code   = 4'($urandom);
      int_save    = ($urandom_range(0, 19) == 0);
      int_restore = ($urandom_range(0, 19) == 0);
      step();
    end

    set_idle(); step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
